mano_control_unit: RTL



---
 rtl/mano_control_unit.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mano_control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit Mano-style basic computer.
// Sole master of the 16x8 memory; holds PC, AR, IR, DR, AC and E.
module mano_control_unit (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] MEM_RDATA,
  output logic [3:0] MEM_AR,
  output logic       MEM_READ,
  output logic       MEM_WRITE,
  output logic [7:0] MEM_WDATA,
  output logic [7:0] AC,
  output logic       E,
  output logic [3:0] PC,
  output logic       HALT
);

  typedef enum logic [2:0] {
    T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3,
    T4 = 3'd4, T5 = 3'd5, T6 = 3'd6
  } sc_t;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;

  sc_t        r_sc;
  sc_t        w_sc_nxt;
  logic [3:0] r_pc;
  logic [3:0] r_ar;
  logic [7:0] r_ir;
  logic [7:0] r_dr;
  logic [7:0] r_ac;
  logic       r_e;
  logic       r_halt;
  logic       r_read;
  logic       r_write;
  logic [7:0] r_wdata;

  logic [2:0] w_op;
  logic       w_i;
  logic       w_rr;
  logic       w_rd_op;
  logic       w_wr_op;
  logic       w_rd_nxt;
  logic       w_wr_nxt;
  logic [7:0] w_ac_rr;

  assign w_op = r_ir[6:4];
  assign w_i  = r_ir[7];
  assign w_rr = (w_op == 3'd7);

  assign w_rd_op = (w_op == OP_AND) || (w_op == OP_ADD) ||
                   (w_op == OP_LDA) || (w_op == OP_ISZ);
  assign w_wr_op = (w_op == OP_STA) || (w_op == OP_BSA);

  // State register
  always_ff @(posedge CLK) begin
    if (RST) r_sc <= T0;
    else     r_sc <= w_sc_nxt;
  end

  // Next-state
  always_comb begin
    w_sc_nxt = T0;
    unique case (r_sc)
      T0: w_sc_nxt = r_halt ? T0 : T1;
      T1: w_sc_nxt = T2;
      T2: w_sc_nxt = T3;
      T3: w_sc_nxt = w_rr ? T0 : T4;
      T4: w_sc_nxt = (w_op == OP_STA || w_op == OP_BUN) ? T0 : T5;
      T5: w_sc_nxt = (w_op == OP_ISZ) ? T6 : T0;
      T6: w_sc_nxt = T0;
      default: w_sc_nxt = T0;
    endcase
  end

  // Strobes registered from the state being entered
  always_comb begin
    w_rd_nxt = 1'b0;
    w_wr_nxt = 1'b0;
    unique case (1'b1)
      (w_sc_nxt == T1): w_rd_nxt = 1'b1;
      (w_sc_nxt == T3): w_rd_nxt = !w_rr && w_i;
      (w_sc_nxt == T4): begin
        w_rd_nxt = w_rd_op;
        w_wr_nxt = w_wr_op;
      end
      (w_sc_nxt == T6): w_wr_nxt = 1'b1;
      default: ;
    endcase
  end

  // Register-reference: CLA, then CMA, then INC
  always_comb begin
    w_ac_rr = r_ac;
    if (r_ir[3]) w_ac_rr = 8'h00;
    if (r_ir[2]) w_ac_rr = ~w_ac_rr;
    if (r_ir[1]) w_ac_rr = w_ac_rr + 8'd1;
  end

  // BSA bumps AR together with the PC load so MEM_AR holds after the write
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pc    <= 4'h0;
      r_ar    <= 4'h0;
      r_ir    <= 8'h00;
      r_dr    <= 8'h00;
      r_ac    <= 8'h00;
      r_e     <= 1'b0;
      r_halt  <= 1'b0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_wdata <= 8'h00;
    end else if (!r_halt) begin
      r_read  <= w_rd_nxt;
      r_write <= w_wr_nxt;
      unique case (r_sc)
        T0: r_ar <= r_pc;
        T1: begin
          r_ir <= MEM_RDATA;
          r_pc <= r_pc + 4'd1;
        end
        T2: begin
          r_ar <= r_ir[3:0];
          if (!w_rr && w_op == OP_STA) r_wdata <= r_ac;
          if (!w_rr && w_op == OP_BSA) r_wdata <= {4'h0, r_pc};
        end
        T3: begin
          if (w_rr) begin
            if (!w_i) begin
              r_ac   <= w_ac_rr;
              r_halt <= r_ir[0];
            end
          end else if (w_i) begin
            r_ar <= MEM_RDATA[3:0];
          end
        end
        T4: begin
          if (w_rd_op) r_dr <= MEM_RDATA;
          if (w_op == OP_ISZ) r_wdata <= MEM_RDATA + 8'd1;
          if (w_op == OP_BUN) r_pc <= r_ar;
        end
        T5: begin
          unique case (w_op)
            OP_AND: r_ac <= r_ac & r_dr;
            OP_ADD: {r_e, r_ac} <= {1'b0, r_ac} + {1'b0, r_dr};
            OP_LDA: r_ac <= r_dr;
            OP_BSA: begin
              r_pc <= r_ar + 4'd1;
              r_ar <= r_ar + 4'd1;
            end
            OP_ISZ: r_dr <= r_dr + 8'd1;
            default: ;
          endcase
        end
        T6: if (r_dr == 8'h00) r_pc <= r_pc + 4'd1;
        default: ;
      endcase
    end
  end

  assign MEM_AR    = r_ar;
  assign MEM_READ  = r_read;
  assign MEM_WRITE = r_write;
  assign MEM_WDATA = r_wdata;
  assign AC        = r_ac;
  assign E         = r_e;
  assign PC        = r_pc;
  assign HALT      = r_halt;

endmodule
